// File: rtl/serial_in_parallel_out_receiver.sv
// Framed serial-to-parallel receiver: assembles INPUT_WIDTH-bit words from a
// qualified serial stream and hands them off through a one-word holding register.
module serial_in_parallel_out_receiver #(
    parameter int INPUT_WIDTH = 8,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   serial_in,
    input  logic                   serial_valid,
    input  logic                   frame_start,
    output logic [INPUT_WIDTH-1:0] parallel_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   frame_error,
    output logic                   overrun
);

    localparam int              CW         = $clog2(INPUT_WIDTH + 1);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(INPUT_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state, state_next;
    logic [INPUT_WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]          count, count_next;
    logic                   word_done;
    logic                   frame_error_next;
    logic                   holding_free;

    function automatic logic [INPUT_WIDTH-1:0] shift_in(input logic [INPUT_WIDTH-1:0] v,
                                                        input logic b);
        if (MSB_FIRST) return {v[INPUT_WIDTH-2:0], b};
        else           return {b, v[INPUT_WIDTH-1:1]};
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next       = state;
        shift_next       = shift_reg;
        count_next       = count;
        word_done        = 1'b0;
        frame_error_next = 1'b0;
        if (serial_valid) begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        shift_next = shift_in('0, serial_in);
                        count_next = CW'(1);
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    // A frame_start inside a word restarts it, even on what
                    // would otherwise be the completing bit.
                    if (frame_start) begin
                        frame_error_next = 1'b1;
                        shift_next       = shift_in('0, serial_in);
                        count_next       = CW'(1);
                    end else begin
                        shift_next = shift_in(shift_reg, serial_in);
                        if (count == LAST_COUNT) begin
                            word_done  = 1'b1;
                            count_next = '0;
                            state_next = IDLE;
                        end else begin
                            count_next = count + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign holding_free = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            count     <= count_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_error <= frame_error_next;
            overrun     <= word_done && !holding_free;
            if (word_done && holding_free) begin
                parallel_out <= shift_next;
                out_valid    <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
